and2_rr_arbiter: RTL and testbench

- Shares one registered 2-input AND datapath (combinational c = a & b, flop d <= c on posedge clk) between NUM_REQ requesters.
- Round-robin arbitration, with an optional bounded lock that gives one requester back-to-back grants.
- Returns the registered result tagged with the winner's index one cycle after grant.
- Sits between micro-benchmark requesters and the shared AND/flop pair as its sequencing controller.

---
 rtl/and2_arb_pkg.sv | 21 ++
 rtl/and2_rr_arbiter_rr_pick.sv | 42 ++++
 rtl/and2_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_and2_rr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/and2_arb_pkg.sv
// Shared types and constants for the round-robin AND arbiter.
//   arb_state_t : FSM state (ARB = no owner, OWN = a requester holds the lock)
//   LOCK_CNT_W  : width of the consecutive-grant counter (LOCK_MAX <= 15)
//   arb_id_w()  : ceil(log2(n)), used to size requester indices
package and2_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    localparam int LOCK_CNT_W = 4;

    function automatic int arb_id_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/and2_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode.
//   i_req  : request vector
//   i_ptr  : index where the scan starts
//   i_excl : requesters removed from this scan
//   o_gnt  : one-hot winner (zero if none)
//   o_idx  : winner index (0 if none)
//   o_any  : a winner exists
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic [N-1:0]  i_excl,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [N-1:0] w_elig;
    assign w_elig = i_req & ~i_excl;

    // Scan offsets from farthest to nearest so the nearest eligible
    // requester (in ptr, ptr+1, ... order) is the last assignment.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (w_elig[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/and2_rr_arbiter.sv
// and2_rr_arbiter: shares one registered AND (d <= a & b) among NUM_REQ
// requesters with round-robin arbitration and an optional bounded lock.
//   clk, rst      : clock, synchronous active-high reset
//   req, lock     : per-requester request and lock hint
//   a, b          : per-requester operands
//   gnt           : one-hot grant, combinational
//   c             : a[w] & b[w] of the granted requester (0 if none)
//   d, d_valid    : registered result and its freshness flag
//   d_id          : index of the requester that produced d
module and2_rr_arbiter
    import and2_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = arb_id_w(NUM_REQ),
    parameter int LOCK_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic [NUM_REQ-1:0] a,
    input  logic [NUM_REQ-1:0] b,
    output logic [NUM_REQ-1:0] gnt,
    output logic               c,
    output logic               d,
    output logic               d_valid,
    output logic [ID_W-1:0]    d_id
);

    localparam logic [LOCK_CNT_W-1:0] CNT_MAX = LOCK_CNT_W'(LOCK_MAX);
    localparam logic [ID_W-1:0]       IDX_TOP = ID_W'(NUM_REQ - 1);

    arb_state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]       r_owner;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic [ID_W-1:0]       r_ptr;
    logic                  r_d, r_d_valid;
    logic [ID_W-1:0]       r_d_id;

    logic [NUM_REQ-1:0] w_owner_oh, w_excl;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic               w_own_hold, w_start_lock;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;

    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

    // Owner keeps the datapath while it still requests, still locks and
    // has not used up its LOCK_MAX grants.
    assign w_own_hold = (r_state == OWN) && req[r_owner] && lock[r_owner]
                        && (r_lock_cnt < CNT_MAX);

    // An exhausted owner steps aside only if someone else is waiting;
    // otherwise it wins the normal scan as a fresh ARB grant.
    assign w_excl = ((r_state == OWN) && (r_lock_cnt == CNT_MAX)
                     && |(req & ~w_owner_oh)) ? w_owner_oh : '0;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .i_req  (req),
        .i_ptr  (r_ptr),
        .i_excl (w_excl),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        if (!rst) begin
            if (w_own_hold) begin
                w_gnt = w_owner_oh;
                w_idx = r_owner;
                w_any = 1'b1;
            end else begin
                w_gnt = w_pick_gnt;
                w_idx = w_pick_idx;
                w_any = w_pick_any;
            end
        end
    end

    assign w_start_lock = !w_own_hold && w_any && lock[w_idx] && (LOCK_MAX > 1);

    always_comb begin
        w_state_nxt = ARB;
        if (w_own_hold || w_start_lock) w_state_nxt = OWN;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ARB;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_ptr      <= '0;
            r_d        <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_id     <= '0;
        end else begin
            if (w_any) begin
                r_d       <= a[w_idx] & b[w_idx];
                r_d_valid <= 1'b1;
                r_d_id    <= w_idx;
                r_ptr     <= (w_idx == IDX_TOP) ? '0 : w_idx + ID_W'(1);
            end else begin
                r_d_valid <= 1'b0;
            end

            if (w_own_hold) begin
                r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
            end else if (w_start_lock) begin
                r_owner    <= w_idx;
                r_lock_cnt <= LOCK_CNT_W'(1);
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    assign gnt     = w_gnt;
    assign c       = |(w_gnt & a & b);
    assign d       = r_d;
    assign d_valid = r_d_valid;
    assign d_id    = r_d_id;

endmodule

// File: tb/tb_and2_rr_arbiter.sv
module tb_and2_rr_arbiter;

    localparam int N  = 4;
    localparam int LM = 4;

    logic         clk, rst;
    logic [N-1:0] req, lock, a, b;
    logic [N-1:0] gnt;
    logic         c, d, d_valid;
    logic [1:0]   d_id;

    int n_cmp = 0;
    int n_bad = 0;

    and2_rr_arbiter #(.NUM_REQ(N), .ID_W(2), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .a(a), .b(b),
        .gnt(gnt), .c(c), .d(d), .d_valid(d_valid), .d_id(d_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who should win this cycle and what the result
    // registers must hold, derived from the arbitration rules directly.
    bit m_ok = 0;
    int m_ptr, m_owner, m_cnt, m_d, m_dv, m_did;
    bit m_own;

    always @(negedge clk) begin
        int  w;
        bit  hold;
        int  ex;
        w = -1; hold = 0; ex = -1;
        if (!rst && m_ok) begin
            if (m_own && req[m_owner] && lock[m_owner] && m_cnt < LM) begin
                w = m_owner; hold = 1;
            end else begin
                if (m_own && m_cnt == LM && ((req & ~(4'(1) << m_owner)) != 0))
                    ex = m_owner;
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (m_ptr + i) % N;
                    if (w < 0 && req[j] && j != ex) w = j;
                end
            end
        end
        if (m_ok) begin
            chk("mdl_gnt", 32'(gnt), (w < 0) ? 0 : (1 << w));
            chk("mdl_c", 32'(c), (w < 0) ? 0 : 32'(a[w] & b[w]));
            chk("mdl_d", 32'(d), m_d);
            chk("mdl_dvalid", 32'(d_valid), m_dv);
            chk("mdl_did", 32'(d_id), m_did);
        end
        if (rst) begin
            m_ok = 1; m_ptr = 0; m_own = 0; m_owner = 0; m_cnt = 0;
            m_d = 0; m_dv = 0; m_did = 0;
        end else if (m_ok) begin
            if (w < 0) begin
                m_dv = 0; m_own = 0;
            end else begin
                m_d = a[w] & b[w]; m_dv = 1; m_did = w; m_ptr = (w + 1) % N;
                if (hold) m_cnt++;
                else if (lock[w] && LM > 1) begin
                    m_own = 1; m_owner = w; m_cnt = 1;
                end else m_own = 0;
            end
        end
    end

    task automatic neg();
        @(negedge clk); #1;
    endtask
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    int lb_exp [9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};

    initial begin
        rst = 1; req = 4'b1111; lock = 0; a = 4'b1111; b = 4'b1111;
        // reset: two cycles with all requesting
        neg(); chk("rst_gnt", 32'(gnt), 0); chk("rst_c", 32'(c), 0);
        cyc();
        neg(); chk("rst_gnt2", 32'(gnt), 0);
        cyc();
        rst = 0;
        // round robin
        for (int k = 0; k < 8; k++) begin
            neg();
            chk("rr_gnt", 32'(gnt), 1 << (k % 4));
            if (k == 0) begin
                chk("rel_d", 32'(d), 0);
                chk("rel_dv", 32'(d_valid), 0);
                chk("rel_did", 32'(d_id), 0);
            end else begin
                chk("rr_did", 32'(d_id), (k - 1) % 4);
                chk("rr_d", 32'(d), 1);
                chk("rr_dv", 32'(d_valid), 1);
            end
            cyc();
        end
        // datapath on requester 2
        req = 4'b0100; a = 4'b0100; b = 4'b0000;
        neg(); chk("dp_gnt", 32'(gnt), 4'b0100); chk("dp_c0", 32'(c), 0); cyc();
        b = 4'b0100;
        neg(); chk("dp_c1", 32'(c), 1); chk("dp_d0", 32'(d), 0); chk("dp_did", 32'(d_id), 2); cyc();
        req = 0;
        neg(); chk("dp_nogr", 32'(gnt), 0); chk("dp_d1", 32'(d), 1); chk("dp_dv1", 32'(d_valid), 1); cyc();
        neg(); chk("dp_dv0", 32'(d_valid), 0); chk("dp_dhold", 32'(d), 1); cyc();
        // lock bound
        req = 4'b0011; lock = 4'b0001; a = 4'b1111; b = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            neg(); chk("lb_gnt", 32'(gnt), lb_exp[k]); cyc();
        end
        // sole locked requester: no bubbles
        req = 4'b0100; lock = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            neg(); chk("sole_gnt", 32'(gnt), 4'b0100); cyc();
        end
        // reset mid-lock: owner 3, lock_cnt 2
        req = 4'b1000; lock = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            neg(); chk("ml_gnt", 32'(gnt), 4'b1000); cyc();
        end
        rst = 1; req = 4'b1010; lock = 0;
        neg(); chk("ml_rgnt", 32'(gnt), 0); chk("ml_rc", 32'(c), 0); cyc();
        rst = 0;
        neg(); chk("ml_first", 32'(gnt), 4'b0010); chk("ml_dv", 32'(d_valid), 0); cyc();
        neg(); chk("ml_ptr", 32'(gnt), 4'b1000); chk("ml_did", 32'(d_id), 1); cyc();
        // random traffic, model-checked
        for (int k = 0; k < 80; k++) begin
            rst  = ($urandom_range(0, 24) == 0);
            req  = 4'($urandom);
            lock = 4'($urandom);
            a    = 4'($urandom);
            b    = 4'($urandom);
            cyc();
        end
        rst = 0; req = 0; lock = 0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
